xor_stream_parity: RTL and testbench

Parametrised, clocked successor to the combinational XOR primitive: applies a bitwise XOR fold across a stream of WIDTH-bit words, one word per handshake. In generate mode it passes the frame through and appends the XOR word as an extra final beat. In check mode it passes the frame through unchanged and reports whether the whole frame, including its trailing check word, folds to zero. It sits between a frame source and a link or sink, on a valid/ready stream.

---
 rtl/xor_stream_parity.sv | 158 +++++++++++++++
 tb/tb_xor_stream_parity.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_parity.sv
// Stream XOR-parity block on a valid/ready link.
// MODE=0 passes each frame through and appends the XOR fold of its data words as one extra
// beat. MODE=1 passes each frame through unchanged and reports whether it folds to zero,
// trailing check word included. Frames longer than MAX_LEN are split at MAX_LEN beats and
// flagged with LEN_ERR.
module xor_stream_parity #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned MODE    = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic             CHK_VALID,
  output logic             CHK_OK,
  output logic             LEN_ERR
);

  localparam int unsigned    LW      = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]  CntLast = LW'(MAX_LEN - 1);
  localparam bit             GenMode = (MODE == 0);

  typedef enum logic [0:0] {StPass, StAppend} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             chk_valid_q, chk_valid_d;
  logic             chk_ok_q, chk_ok_d;
  logic             len_err_q, len_err_d;

  logic             load_en;
  logic             accept;
  logic             terminal;
  logic [WIDTH-1:0] fold;

  // Output register can take a new word when empty or being drained this cycle.
  assign load_en  = !out_valid_q || OUT_READY;
  // No input is taken while the parity beat is pending, nor while reset is held.
  assign IN_READY = (state_q == StPass) && load_en && !RST;
  assign accept   = IN_VALID && IN_READY;
  // Beat MAX_LEN of a frame closes it even without IN_LAST.
  assign terminal = IN_LAST || (cnt_q == CntLast);
  assign fold     = acc_q ^ IN_DATA;

  // Next-state logic: a terminal beat in generate mode schedules the parity beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPass: begin
        if (accept && terminal && GenMode) begin
          state_d = StAppend;
        end
      end
      StAppend: begin
        if (load_en) begin
          state_d = StPass;
        end
      end
      default: state_d = StPass;
    endcase
  end

  // Datapath next-state: fold accumulator, beat counter, output register and pulses.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
    len_err_d   = 1'b0;

    if (state_q == StAppend) begin
      if (load_en) begin
        out_valid_d = 1'b1;
        out_data_d  = par_q;
        out_last_d  = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = IN_DATA;
      // In generate mode the appended parity beat carries LAST, never a data beat.
      out_last_d  = !GenMode && terminal;
      if (terminal) begin
        acc_d     = '0;
        cnt_d     = '0;
        len_err_d = !IN_LAST;
        if (GenMode) begin
          par_d = fold;
        end else begin
          chk_valid_d = 1'b1;
          chk_ok_d    = (fold == '0);
        end
      end else begin
        acc_d = fold;
        cnt_d = cnt_q + LW'(1);
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset drops any partial frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StPass;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      par_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      len_err_q   <= len_err_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LAST  = out_last_q;
  assign CHK_VALID = chk_valid_q;
  assign CHK_OK    = chk_ok_q;
  assign LEN_ERR   = len_err_q;

endmodule

// File: tb/tb_xor_stream_parity.sv
// Bench for xor_stream_parity: three instances (generate/16, check/16, generate/4) driven
// with directed and random frames, checked against a frame-level reference model.
module tb_xor_stream_parity;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [W-1:0] in_data   [3];
  logic         in_last   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] out_data  [3];
  logic         out_last  [3];
  logic         chk_valid [3];
  logic         chk_ok    [3];
  logic         len_err   [3];

  int total = 0;
  int bad   = 0;

  int mode_k   [3] = '{0, 1, 0};
  int maxlen_k [3] = '{16, 16, 4};
  int stall_pct[3] = '{0, 0, 0};

  // Reference model state, one slot per instance.
  logic [W-1:0] m_acc [3];
  int           m_cnt [3];
  bit           m_app [3];
  logic [W-1:0] m_par [3];
  bit           e_load[3];
  logic [W-1:0] e_dat [3];
  bit           e_last[3];
  bit           e_chk [3];
  bit           e_ok  [3];
  bit           e_len [3];
  bit           h_on  [3];
  logic [W-1:0] h_dat [3];
  bit           h_last[3];
  logic [W-1:0] last_par[3];
  int           n_chk [3];
  int           n_len [3];
  logic [W:0]   q0[$];
  logic [W:0]   q1[$];
  logic [W:0]   q2[$];

  always #5 clk = ~clk;

  xor_stream_parity #(.WIDTH(W), .MAX_LEN(16), .MODE(0)) u_gen (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .IN_DATA(in_data[0]), .IN_LAST(in_last[0]), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready[0]), .OUT_DATA(out_data[0]), .OUT_LAST(out_last[0]),
    .CHK_VALID(chk_valid[0]), .CHK_OK(chk_ok[0]), .LEN_ERR(len_err[0])
  );

  xor_stream_parity #(.WIDTH(W), .MAX_LEN(16), .MODE(1)) u_chk (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .IN_DATA(in_data[1]), .IN_LAST(in_last[1]), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready[1]), .OUT_DATA(out_data[1]), .OUT_LAST(out_last[1]),
    .CHK_VALID(chk_valid[1]), .CHK_OK(chk_ok[1]), .LEN_ERR(len_err[1])
  );

  xor_stream_parity #(.WIDTH(W), .MAX_LEN(4), .MODE(0)) u_small (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .IN_DATA(in_data[2]), .IN_LAST(in_last[2]), .OUT_VALID(out_valid[2]),
    .OUT_READY(out_ready[2]), .OUT_DATA(out_data[2]), .OUT_LAST(out_last[2]),
    .CHK_VALID(chk_valid[2]), .CHK_OK(chk_ok[2]), .LEN_ERR(len_err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void q_push(input int k, input logic [W:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [W:0] q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void model_clear(input int k);
    m_acc[k] = '0; m_cnt[k] = 0; m_app[k] = 1'b0;
    e_load[k] = 1'b0; e_chk[k] = 1'b0; e_len[k] = 1'b0; h_on[k] = 1'b0;
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // One model step per cycle, sampled just before the rising edge.
  task automatic sample(input int k);
    string p;
    logic [W:0] e;
    bit term;
    p = $sformatf("k%0d", k);
    if (rst) begin
      check({p, "_rst_ready"}, 32'(in_ready[k]), 0);
      model_clear(k);
      return;
    end
    check({p, "_chk_valid"}, 32'(chk_valid[k]), 32'(e_chk[k]));
    if (e_chk[k] && chk_valid[k]) check({p, "_chk_ok"}, 32'(chk_ok[k]), 32'(e_ok[k]));
    if (chk_valid[k]) n_chk[k]++;
    check({p, "_len_err"}, 32'(len_err[k]), 32'(e_len[k]));
    if (len_err[k]) n_len[k]++;
    if (e_load[k]) begin
      check({p, "_load_valid"}, 32'(out_valid[k]), 1);
      check({p, "_load_data"}, 32'(out_data[k]), 32'(e_dat[k]));
      check({p, "_load_last"}, 32'(out_last[k]), 32'(e_last[k]));
    end
    if (h_on[k]) begin
      check({p, "_hold_valid"}, 32'(out_valid[k]), 1);
      check({p, "_hold_data"}, 32'(out_data[k]), 32'(h_dat[k]));
      check({p, "_hold_last"}, 32'(out_last[k]), 32'(h_last[k]));
    end
    check({p, "_in_ready"}, 32'(in_ready[k]),
          32'(!m_app[k] && (!out_valid[k] || out_ready[k])));

    e_load[k] = 1'b0; e_chk[k] = 1'b0; e_len[k] = 1'b0;
    h_on[k]   = out_valid[k] && !out_ready[k];
    h_dat[k]  = out_data[k];
    h_last[k] = out_last[k];

    if (out_valid[k] && out_ready[k]) begin
      if (q_size(k) == 0) begin
        check({p, "_spurious"}, 32'(out_valid[k]), 0);
      end else begin
        e = q_pop(k);
        check({p, "_out_data"}, 32'(out_data[k]), 32'(e[W-1:0]));
        check({p, "_out_last"}, 32'(out_last[k]), 32'(e[W]));
        if (out_last[k] && mode_k[k] == 0) last_par[k] = out_data[k];
      end
    end

    if (m_app[k] && (!out_valid[k] || out_ready[k])) begin
      e_load[k] = 1'b1; e_dat[k] = m_par[k]; e_last[k] = 1'b1; m_app[k] = 1'b0;
    end

    if (in_valid[k] && in_ready[k]) begin
      m_acc[k] = m_acc[k] ^ in_data[k];
      m_cnt[k]++;
      term = in_last[k] || (m_cnt[k] == maxlen_k[k]);
      e_load[k] = 1'b1;
      e_dat[k]  = in_data[k];
      if (mode_k[k] == 0) begin
        e_last[k] = 1'b0;
        q_push(k, {1'b0, in_data[k]});
        if (term) begin
          q_push(k, {1'b1, m_acc[k]});
          m_par[k] = m_acc[k];
          m_app[k] = 1'b1;
        end
      end else begin
        e_last[k] = term;
        q_push(k, {term, in_data[k]});
        if (term) begin
          e_chk[k] = 1'b1;
          e_ok[k]  = (m_acc[k] == '0);
        end
      end
      e_len[k] = term && !in_last[k];
      if (term) begin
        m_acc[k] = '0;
        m_cnt[k] = 0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      model_clear(k);
      n_chk[k] = 0; n_len[k] = 0; last_par[k] = '0;
    end
    forever begin
      @(negedge clk);
      #4;
      for (int k = 0; k < 3; k++) sample(k);
    end
  end

  // Random downstream back-pressure.
  initial begin
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) out_ready[k] = (int'($urandom_range(99)) >= stall_pct[k]);
    end
  end

  // Present one beat (after optional random idle cycles) and hold it until accepted.
  task automatic send_beat(input int k, input logic [W-1:0] d, input bit last, input int gap);
    int n = 0;
    while (int'($urandom_range(99)) < gap) begin
      in_valid[k] = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b1; in_data[k] = d; in_last[k] = last;
    forever begin
      @(negedge clk);
      #4;
      if (in_ready[k]) break;
      n++;
      if (n > 500) begin
        check($sformatf("k%0d_accept_timeout", k), 32'(in_ready[k]), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (q_size(k) != 0 || m_app[k] || out_valid[k]) begin
      @(posedge clk);
      n++;
      if (n > 2000) begin
        check($sformatf("k%0d_drain_timeout", k), 32'(q_size(k)), 0);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_frames(input int k, input int frames, input int max_len, input bit fix);
    logic [W-1:0] acc;
    logic [W-1:0] d;
    int len;
    for (int f = 0; f < frames; f++) begin
      len = int'($urandom_range(max_len - 1)) + 1;
      acc = '0;
      for (int i = 0; i < len; i++) begin
        d = W'($urandom);
        // Half the check-mode frames end in a correct check word.
        if (fix && i == len - 1 && $urandom_range(1) == 1) d = acc;
        acc = acc ^ d;
        send_beat(k, d, (i == len - 1), 30);
      end
    end
    idle(k);
    drain(k);
  endtask

  int nc;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_last[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d_rst_out_valid", k), 32'(out_valid[k]), 0);
      check($sformatf("k%0d_rst_out_data", k), 32'(out_data[k]), 0);
      check($sformatf("k%0d_rst_out_last", k), 32'(out_last[k]), 0);
      check($sformatf("k%0d_rst_chk", k), 32'({chk_valid[k], chk_ok[k]}), 0);
      check($sformatf("k%0d_rst_len_err", k), 32'(len_err[k]), 0);
      check($sformatf("k%0d_rst_in_ready", k), 32'(in_ready[k]), 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Generate mode: 12 34 56 -> parity 70.
    send_beat(0, 8'h12, 1'b0, 0);
    send_beat(0, 8'h34, 1'b0, 0);
    send_beat(0, 8'h56, 1'b1, 0);
    idle(0);
    drain(0);
    check("gen_parity", 32'(last_par[0]), 32'h70);

    // Check mode: good then corrupted check word.
    nc = n_chk[1];
    send_beat(1, 8'h12, 1'b0, 0);
    send_beat(1, 8'h34, 1'b0, 0);
    send_beat(1, 8'h56, 1'b0, 0);
    send_beat(1, 8'h70, 1'b1, 0);
    idle(1);
    drain(1);
    check("chk_good_pulses", 32'(n_chk[1] - nc), 1);
    check("chk_good_ok", 32'(chk_ok[1]), 1);
    send_beat(1, 8'h12, 1'b0, 0);
    send_beat(1, 8'h34, 1'b0, 0);
    send_beat(1, 8'h56, 1'b0, 0);
    send_beat(1, 8'h71, 1'b1, 0);
    idle(1);
    drain(1);
    check("chk_bad_pulses", 32'(n_chk[1] - nc), 2);
    check("chk_bad_ok", 32'(chk_ok[1]), 0);

    // Single-beat frames.
    send_beat(0, 8'hA5, 1'b1, 0);
    idle(0);
    drain(0);
    check("gen_single_parity", 32'(last_par[0]), 32'hA5);
    send_beat(1, 8'hA5, 1'b1, 0);
    idle(1);
    drain(1);
    check("chk_single_a5", 32'(chk_ok[1]), 0);
    send_beat(1, 8'h00, 1'b1, 0);
    idle(1);
    drain(1);
    check("chk_single_00", 32'(chk_ok[1]), 1);

    // MAX_LEN=4 overrun: beats 1-4 closed by length, 5-6 open a new frame.
    send_beat(2, 8'h11, 1'b0, 0);
    send_beat(2, 8'h22, 1'b0, 0);
    send_beat(2, 8'h44, 1'b0, 0);
    send_beat(2, 8'h88, 1'b0, 0);
    send_beat(2, 8'h05, 1'b0, 0);
    send_beat(2, 8'h06, 1'b0, 0);
    idle(2);
    drain(2);
    check("len_err_count", 32'(n_len[2]), 1);
    check("len_split_parity", 32'(last_par[2]), 32'hFF);
    send_beat(2, 8'h30, 1'b1, 0);
    idle(2);
    drain(2);
    check("len_tail_parity", 32'(last_par[2]), 32'h33);
    check("len_err_count_after", 32'(n_len[2]), 1);

    // Random traffic with back-pressure on all three instances.
    stall_pct = '{50, 50, 30};
    fork
      rand_frames(0, 100, 20, 1'b0);
      rand_frames(1, 40, 8, 1'b1);
      rand_frames(2, 30, 7, 1'b0);
    join
    stall_pct = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset after two beats of a frame.
    send_beat(0, 8'hAA, 1'b0, 0);
    send_beat(0, 8'h55, 1'b0, 0);
    idle(0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid[0]), 0);
    check("arst_out_data", 32'(out_data[0]), 0);
    check("arst_out_last", 32'(out_last[0]), 0);
    check("arst_in_ready", 32'(in_ready[0]), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(0, 8'h0F, 1'b0, 0);
    send_beat(0, 8'hF0, 1'b1, 0);
    idle(0);
    drain(0);
    check("arst_parity", 32'(last_par[0]), 32'hFF);

    for (int k = 0; k < 3; k++) check($sformatf("k%0d_leftover", k), 32'(q_size(k)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
